// File: rtl/synth_note_reg_writer_pkg.sv
// Shared constants for the note-to-register writer: voice register bases, FSM states, voice entry.
package synth_note_reg_writer_pkg;

   localparam int CAR_BASE   = 0;
   localparam int MOD_BASE   = 16;
   localparam int VEL_BASE   = 32;
   localparam int MAX_VOICES = 16;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      WR_CAR,
      WR_MOD,
      WR_VEL
   } state_t;

   typedef struct packed {
      logic       busy;
      logic [6:0] note;
   } voice_t;

endpackage

// File: rtl/synth_note_reg_writer_if.sv
// Note-event input and register-write output bundle of the note writer.
// master = the writer block, slave = event source plus register file.
interface synth_note_reg_writer_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
);
   logic              ev_valid;
   logic              ev_ready;
   logic              ev_note_on;
   logic [6:0]        ev_note;
   logic [6:0]        ev_vel;
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport master (
      input  ev_valid, ev_note_on, ev_note, ev_vel, wr_ready,
      output ev_ready, wr_valid, wr_addr, wr_data
   );

   modport slave (
      output ev_valid, ev_note_on, ev_note, ev_vel, wr_ready,
      input  ev_ready, wr_valid, wr_addr, wr_data
   );
endinterface

// File: rtl/synth_note_reg_writer_note_to_phase_inc.sv
// MIDI note to phase-increment lookup: 128-entry table built at elaboration, one-cycle registered output.
module note_to_phase_inc #(
   parameter int DATA_W = 32,
   parameter int FS_HZ  = 48000
) (
   input  logic              clk,
   input  logic [6:0]        note,
   output logic [DATA_W-1:0] inc
);

   // round(f_note / FS_HZ * 2^DATA_W), with A4 (note 69) at 440 Hz
   function automatic logic [DATA_W-1:0] calc_inc(input int n);
      real f;
      f = 440.0 * (2.0 ** ((real'(n) - 69.0) / 12.0)) / real'(FS_HZ)
          * (2.0 ** real'(DATA_W));
      return DATA_W'($rtoi(f + 0.5));
   endfunction

   logic [DATA_W-1:0] rom [128];

   for (genvar g = 0; g < 128; g++) begin : g_rom
      localparam logic [DATA_W-1:0] INC = calc_inc(g);
      assign rom[g] = INC;
   end

   always_ff @(posedge clk) begin
      inc <= rom[note];
   end

endmodule

// File: rtl/synth_note_reg_writer.sv
// Note event to voice register writer with lowest-free voice allocation.
// Build option SYNTH_VOICE_STEAL_EN: steal voices round-robin when all are busy instead of dropping.
//
// state  | meaning
// IDLE   | waiting for a note event, ev_ready=1
// LOOKUP | voice search; phase-increment ROM registers
// WR_CAR | write carrier increment
// WR_MOD | write modulator increment
// WR_VEL | write velocity (0 for note-off)
module synth_note_reg_writer
   import synth_note_reg_writer_pkg::*;
#(
   parameter int NUM_VOICES = 16,
   parameter int ADDR_W     = 6,
   parameter int DATA_W     = 32,
   parameter int FS_HZ      = 48000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   synth_note_reg_writer_if.master bus,
   input  logic [7:0]            mod_ratio,
   output logic [NUM_VOICES-1:0] voices_busy,
   output logic [15:0]           drop_cnt
);

   localparam int VIDX_W = 4;

   state_t                  state, state_d;
   voice_t                  voices [NUM_VOICES];
   logic [6:0]              note_q;
   logic [6:0]              vel_q;
   logic                    on_q;
   logic [7:0]              ratio_q;
   logic [VIDX_W-1:0]       voice_q;
   logic                    accept;
   logic                    match_hit;
   logic                    free_hit;
   logic [VIDX_W-1:0]       match_idx;
   logic [VIDX_W-1:0]       free_idx;
   logic [DATA_W-1:0]       car_inc;
   logic [DATA_W+7:0]       mod_prod;
`ifdef SYNTH_VOICE_STEAL_EN
   logic [VIDX_W-1:0]       steal_ptr;
`endif

   note_to_phase_inc #(
      .DATA_W (DATA_W),
      .FS_HZ  (FS_HZ)
   ) u_note_to_phase_inc (
      .clk  (clk),
      .note (note_q),
      .inc  (car_inc)
   );

   assign accept   = (state == IDLE) && bus.ev_valid;
   assign mod_prod = {8'd0, car_inc} * {{DATA_W{1'b0}}, ratio_q};

   // Descending scan so the lowest matching / free index is the one left standing
   always_comb begin
      match_hit = 1'b0;
      match_idx = '0;
      free_hit  = 1'b0;
      free_idx  = '0;
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (voices[i].busy && (voices[i].note == note_q)) begin
            match_hit = 1'b1;
            match_idx = VIDX_W'(i);
         end
         if (!voices[i].busy) begin
            free_hit = 1'b1;
            free_idx = VIDX_W'(i);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_VOICES; i++) begin
         voices_busy[i] = voices[i].busy;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d      = state;
      bus.ev_ready = 1'b0;
      bus.wr_valid = 1'b0;
      bus.wr_addr  = '0;
      bus.wr_data  = '0;
      case (state)
         IDLE: begin
            bus.ev_ready = rst_n;
            if (bus.ev_valid) begin
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            if (on_q) begin
`ifdef SYNTH_VOICE_STEAL_EN
               state_d = WR_CAR;
`else
               state_d = (match_hit || free_hit) ? WR_CAR : IDLE;
`endif
            end else begin
               state_d = match_hit ? WR_VEL : IDLE;
            end
         end
         WR_CAR: begin
            bus.wr_valid = rst_n;
            bus.wr_addr  = ADDR_W'(CAR_BASE) + ADDR_W'(voice_q);
            bus.wr_data  = car_inc;
            if (bus.wr_ready) begin
               state_d = WR_MOD;
            end
         end
         WR_MOD: begin
            bus.wr_valid = rst_n;
            bus.wr_addr  = ADDR_W'(MOD_BASE) + ADDR_W'(voice_q);
            bus.wr_data  = mod_prod[DATA_W+3:4];
            if (bus.wr_ready) begin
               state_d = WR_VEL;
            end
         end
         WR_VEL: begin
            bus.wr_valid = rst_n;
            bus.wr_addr  = ADDR_W'(VEL_BASE) + ADDR_W'(voice_q);
            bus.wr_data  = on_q ? DATA_W'(vel_q) : '0;
            if (bus.wr_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         note_q   <= '0;
         vel_q    <= '0;
         on_q     <= 1'b0;
         ratio_q  <= '0;
         voice_q  <= '0;
         voices   <= '{default: '0};
         drop_cnt <= '0;
`ifdef SYNTH_VOICE_STEAL_EN
         steal_ptr <= '0;
`endif
      end else begin
         if (accept) begin
            note_q  <= bus.ev_note;
            vel_q   <= bus.ev_vel;
            on_q    <= bus.ev_note_on && (bus.ev_vel != 7'd0);
            ratio_q <= mod_ratio;
         end
         if (state == LOOKUP) begin
            if (on_q) begin
               if (match_hit) begin
                  voice_q <= match_idx;
               end else if (free_hit) begin
                  voice_q               <= free_idx;
                  voices[free_idx].busy <= 1'b1;
                  voices[free_idx].note <= note_q;
               end else begin
`ifdef SYNTH_VOICE_STEAL_EN
                  voice_q                <= steal_ptr;
                  voices[steal_ptr].note <= note_q;
                  steal_ptr <= (steal_ptr == VIDX_W'(NUM_VOICES - 1)) ? '0 : steal_ptr + 1'b1;
`else
                  if (drop_cnt != 16'hFFFF) begin
                     drop_cnt <= drop_cnt + 16'd1;
                  end
`endif
               end
            end else if (match_hit) begin
               voice_q                <= match_idx;
               voices[match_idx].busy <= 1'b0;
            end
         end
      end
   end

endmodule

// File: doc/synth_note_reg_writer.md
Name: synth_note_reg_writer

Overview:
- Converts incoming note events (note-on/note-off with velocity) into write transactions on the synth register bus.
- Performs per-voice allocation over NUM_VOICES voices.
- Writes carrier increment, modulator increment and velocity registers for the chosen voice.
- Sits between the MIDI/event front end and the voice register file, acting as the initiator of that register map.

Parameters:
- NUM_VOICES, 16, voices managed; must be ≤16 to fit the address map.
- ADDR_W, 6, register address width.
- DATA_W, 32, register data width (equals the phase accumulator width).
- FS_HZ, 48000, sample rate used to build the phase-increment ROM.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, synchronous active-low reset.
- ev_valid, in, 1, note event valid.
- ev_ready, out, 1, block can accept an event.
- ev_note_on, in, 1, 1 = note-on, 0 = note-off.
- ev_note, in, 7, MIDI note number.
- ev_vel, in, 7, MIDI velocity.
- mod_ratio, in, 8, modulator/carrier ratio, unsigned 4.4 fixed point.
- wr_valid, out, 1, register write valid.
- wr_ready, in, 1, register write accepted.
- wr_addr, out, ADDR_W, register address.
- wr_data, out, DATA_W, register data.
- voices_busy, out, NUM_VOICES, per-voice active flag.
- drop_cnt, out, 16, count of dropped note-ons, saturating.

Behaviour:
- Reset: clock is one domain, clk; reset rst_n is synchronous and active-low.
  - State returns to IDLE.
  - ev_ready=0 during reset and 1 on the first cycle after reset.
  - wr_valid=0, wr_addr=0, wr_data=0.
  - voices_busy=0, drop_cnt=0.
  - All voice note entries are cleared.
  - A reset mid-transaction abandons the write immediately, with no completion.
- Address map:
  - Carrier registers: voice v at address v.
  - Modulator registers: voice v at 16+v.
  - Velocity registers: voice v at 32+v.
- Event handshake:
  - ev_ready=1 only in IDLE.
  - An event is accepted on ev_valid&&ev_ready, and note/vel/on/mod_ratio are latched.
  - A note-on with vel=0 is treated as a note-off.
- States: IDLE → LOOKUP → WR_CAR → WR_MOD → WR_VEL → IDLE.
- LOOKUP (exactly 1 cycle): the phase-increment ROM output registers during this cycle.
  - Note-on, and the note is already held by voice v: retrigger v; no table change.
  - Note-on, otherwise: allocate the lowest-index inactive voice and set busy[v]=1 at the end of LOOKUP.
  - Note-on, no free voice: handled per the optional feature.
  - Note-off matching voice v: clear busy[v] at the end of LOOKUP, then go directly to WR_VEL with data 0.
  - Note-off with no match: return to IDLE with no writes.
  - If several voices match (impossible by construction), the lowest index wins.
- Write states: wr_valid=1, and addr/data are held stable until wr_ready. Advance on the wr_valid&&wr_ready cycle.
  - wr_ready is sampled only, with no combinational path to ev_ready.
  - WR_CAR data = car_inc = round(440·2^((n−69)/12)/FS_HZ·2^DATA_W).
  - WR_MOD data = (car_inc × mod_ratio) >> 4. The product is 40 bits; keep the low DATA_W bits after the shift (truncate).
  - WR_VEL data = zero-extended ev_vel (or 0 for note-off).
- Back-to-back: the next event can be accepted the cycle after the final write handshake.
  - The minimum note-on cost is 5 cycles with wr_ready tied high.
- drop_cnt saturates at 0xFFFF.

Optional Feature:
- Macro: SYNTH_VOICE_STEAL_EN.
- Defined: a note-on with all voices busy steals voice steal_ptr.
  - Overwrite its note, keep busy=1, perform the full 3-write sequence.
  - Advance steal_ptr modulo NUM_VOICES on each steal.
  - steal_ptr resets to 0.
  - drop_cnt is unaffected.
- Undefined: the note-on is accepted and discarded, drop_cnt increments, and the block returns to IDLE with no writes.

Decomposition:
- Shared constants package (the existing synth constants package) holds:
  - the voice-register base addresses;
  - the FSM state enum type;
  - the voice entry struct (busy bit, 7-bit note).
- Sub-module: note_to_phase_inc.
  - 128-entry ROM generated at elaboration from FS_HZ/DATA_W.
  - Registered output, 1-cycle latency.

Test Plan:
1. Note-on note=69 vel=100, mod_ratio=0x10, wr_ready=1 → writes (0, 39370534), (16, 39370534), (32, 100); busy=0x0001; ev_ready returns 5 cycles after accept.
2. Note-on 60 then 64, then note-off 60 → second note uses voice 1 (addr 1/17/33); note-off writes only (32, 0); busy goes 0x0003 → 0x0002.
3. wr_ready held low 10 cycles during WR_MOD → wr_valid stays 1 and addr/data stay stable; ev_ready=0 throughout; sequence completes after wr_ready rises.
4. 17 distinct note-ons, macro undefined → 17th produces no writes and drop_cnt=1; with macro defined → 17th writes addr 0/16/32 and steal_ptr=1.
5. Note-on 72 vel=0 while 72 is held on voice 3 → single write (35, 0); busy[3] cleared. Note-off 50 (not held) → no writes.
6. rst_n asserted while in WR_CAR with wr_ready=0 → next cycle wr_valid=0, busy=0, drop_cnt=0, ev_ready=1 one cycle after rst_n releases.
